mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the cache block.
- Consumes its instruction and data memory requests (iREN/iaddr, dREN/dWEN/daddr/dstore) and serialises them onto the single-port RAM.
- Returns iwait/dwait and load data back to the caches.
- Registered FSM: grants one requester at a time, latches the request, and holds the RAM strobes until the RAM reports ACCESS or ERROR.

Parameters:
- ADDR_W, 32, byte address width of iaddr/daddr/ramaddr.
- DATA_W, 32, word width (matches word_t).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  instruction stall; low for exactly the completion cycle.
- iload  out  DATA_W  instruction data, valid when iREN & ~iwait.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; never asserted together with dREN.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dwait  out  1  data stall; low for exactly the completion cycle.
- dload  out  DATA_W  read data, valid when dREN & ~dwait.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky: RAM returned ERROR during a granted access.

Behaviour:
- States: IDLE, DSERV, ISERV (arb_state_t).
- Reset values: state=IDLE, latched addr/data/we=0, err=0, last_grant=INSTR.
- Outputs during reset: iwait=dwait=1, ramREN=ramWEN=0, iload=dload=0.
- IDLE:
  - RAM strobes low; iwait=dwait=1.
  - Grant is decided on the current inputs and latched at the clock edge.
  - If dREN|dWEN: next state DSERV; latch daddr, dstore, dWEN.
  - Else if iREN: next state ISERV; latch iaddr.
  - Else stay in IDLE.
- DSERV:
  - ramaddr=latched daddr; ramWEN=latched we; ramREN=~latched we; ramstore=latched dstore.
  - iwait=1 throughout.
  - ramstate FREE/BUSY: hold state; dwait=1.
  - ramstate ACCESS: dwait=0 this cycle (combinational); dload=ramload; next state IDLE.
- ISERV: same as DSERV using the instruction side; ramWEN=0 always; iload=ramload on ACCESS.
- Completion always returns to IDLE, so there is exactly one bubble cycle between back-to-back grants. This prevents double-servicing a request whose strobe falls one cycle after completion.
- Minimum latency: 2 cycles from request to completion (grant cycle plus ACCESS cycle).
- ramstate ERROR while serving: wait stays 1; err<=1 (sticky until RST); next state IDLE. The still-asserted request is retried from IDLE.
- Withdrawal: if the granted requester drops its strobe(s) before ACCESS, RAM strobes go low that same cycle, no completion is signalled, and the next state is IDLE.
- Address or data changes mid-service are ignored; the latched values are used.
- RST asserted mid-access: immediate return to reset values; RAM strobes drop asynchronously.
- iload/dload are 0 whenever they are not completing.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: a last_grant register is updated on each completion. In IDLE with both sides requesting, the side not granted last wins.
- Undefined: fixed priority, data always beats instruction; last_grant is not implemented.

Decomposition:
- cpu_types_pkg gains arb_state_t {IDLE, DSERV, ISERV} and the requester_t {INSTR, DATA} enum.
- word_t and ramstate_t are reused from cpu_types_pkg.
- No sub-module: the grant decision is a few lines of combinational logic inside the FSM block.

Test Plan:
- Reset: RST=1 mid-DSERV with ramstate=BUSY -> ramREN/ramWEN=0 immediately; iwait=dwait=1; err=0.
- Single instruction read: iREN=1, iaddr=0x40, ramstate BUSY x2 then ACCESS, ramload=0xDEADBEEF -> ramaddr=0x40 from cycle 1; iwait=0 and iload=0xDEADBEEF exactly on the ACCESS cycle; total 4 cycles.
- Data write: dWEN=1, daddr=0x100, dstore=0x12345678, immediate ACCESS -> ramWEN=1, ramstore=0x12345678; dwait low in cycle 1; state IDLE in cycle 2.
- Contention: iREN and dREN both held from cycle 0.
  - Without ARB_RR_EN: data completes first, then a bubble, then instruction is granted.
  - With ARB_RR_EN and last_grant=DATA: instruction is granted first.
- Error: granted read with ramstate=ERROR -> err=1, dwait stays 1, re-grant from IDLE; a later ACCESS completes the read and err stays 1.
- Withdrawal: dREN drops while ramstate=BUSY -> ramREN low that cycle; dwait never goes low; a pending iREN is granted 2 cycles later.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/RAM handshake types plus the memory arbiter's state
// and requester encodings.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t DSERV = 2'd1;
    localparam arb_state_t ISERV = 2'd2;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } requester_t;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises cache instruction/data requests onto a single-port RAM.
// ARB_RR_EN: alternate grants on contention instead of fixed data priority.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              err
);

    arb_state_t        state, next_state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_we;
    logic              d_req, grant_d, grant_i, set_err, prefer_i;

    assign d_req    = dREN | dWEN;
    assign ramaddr  = lat_addr;
    assign ramstore = lat_data;

`ifdef ARB_RR_EN
    requester_t last_grant;

    assign prefer_i = (last_grant == DATA);

    // Remember who completed last so contention alternates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= INSTR;
        end else if (!dwait) begin
            last_grant <= DATA;
        end else if (!iwait) begin
            last_grant <= INSTR;
        end
    end
`else
    assign prefer_i = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latches and sticky error flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_we   <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (grant_d) begin
                lat_addr <= daddr;
                lat_data <= dstore;
                lat_we   <= dWEN;
            end else if (grant_i) begin
                lat_addr <= iaddr;
                lat_we   <= 1'b0;
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        set_err    = 1'b0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        case (state)
            IDLE: begin
                grant_d = d_req & ~(iREN & prefer_i);
                grant_i = iREN & ~grant_d;
                if (grant_d) begin
                    next_state = DSERV;
                end else if (grant_i) begin
                    next_state = ISERV;
                end
            end
            DSERV: begin
                // A withdrawn request drops the strobes with no completion.
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ramWEN = lat_we;
                    ramREN = ~lat_we;
                    if (ramstate == ACCESS) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        next_state = IDLE;
                    end else if (ramstate == ERROR) begin
                        set_err    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            ISERV: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        next_state = IDLE;
                    end else if (ramstate == ERROR) begin
                        set_err    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; contention order follows ARB_RR_EN.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    ramstate_t   ramstate;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        ramstate = FREE;
    endtask

    initial begin
        RST = 1'b1;
        quiet();
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        #2;
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_loads", iload | dload, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        RST = 1'b0;

        // Instruction read: BUSY, BUSY, ACCESS
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'hDEADBEEF;
        #1;
        chk("ird_c0_ramREN", 32'(ramREN), 32'd0);
        tick();
        chk("ird_c1_ramREN", 32'(ramREN), 32'd1);
        chk("ird_c1_ramaddr", ramaddr, 32'h40);
        chk("ird_c1_iwait", 32'(iwait), 32'd1);
        chk("ird_c1_iload", iload, 32'd0);
        tick();
        chk("ird_c2_iwait", 32'(iwait), 32'd1);
        tick();
        ramstate = ACCESS;
        #1;
        chk("ird_c3_iwait", 32'(iwait), 32'd0);
        chk("ird_c3_iload", iload, 32'hDEADBEEF);
        chk("ird_c3_dwait", 32'(dwait), 32'd1);
        tick();
        quiet();
        #1;
        chk("ird_done_iwait", 32'(iwait), 32'd1);
        chk("ird_done_ramREN", 32'(ramREN), 32'd0);
        chk("ird_done_iload", iload, 32'd0);

        // Data write, immediate ACCESS; mid-service address change ignored
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678; ramstate = ACCESS;
        #1;
        chk("dwr_c0_dwait", 32'(dwait), 32'd1);
        chk("dwr_c0_ramWEN", 32'(ramWEN), 32'd0);
        tick();
        daddr = 32'h200;
        #1;
        chk("dwr_c1_ramWEN", 32'(ramWEN), 32'd1);
        chk("dwr_c1_ramREN", 32'(ramREN), 32'd0);
        chk("dwr_c1_ramstore", ramstore, 32'h12345678);
        chk("dwr_c1_ramaddr", ramaddr, 32'h100);
        chk("dwr_c1_dwait", 32'(dwait), 32'd0);
        tick();
        chk("dwr_c2_ramWEN", 32'(ramWEN), 32'd0);
        chk("dwr_c2_dwait", 32'(dwait), 32'd1);
        quiet();
        tick();

        // Contention: both requesting from cycle 0
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300;
        ramstate = ACCESS; ramload = 32'hA5A5A5A5;
        tick();
`ifdef ARB_RR_EN
        chk("con_c1_iwait", 32'(iwait), 32'd0);
        chk("con_c1_ramaddr", ramaddr, 32'h80);
        chk("con_c1_dwait", 32'(dwait), 32'd1);
        tick();
        iREN = 1'b0;
        #1;
        chk("con_c2_bubble", 32'(ramREN), 32'd0);
        tick();
        chk("con_c3_dwait", 32'(dwait), 32'd0);
        chk("con_c3_dload", dload, 32'hA5A5A5A5);
        chk("con_c3_ramaddr", ramaddr, 32'h300);
`else
        chk("con_c1_dwait", 32'(dwait), 32'd0);
        chk("con_c1_dload", dload, 32'hA5A5A5A5);
        chk("con_c1_ramaddr", ramaddr, 32'h300);
        chk("con_c1_iwait", 32'(iwait), 32'd1);
        tick();
        dREN = 1'b0;
        #1;
        chk("con_c2_bubble", 32'(ramREN), 32'd0);
        chk("con_c2_iwait", 32'(iwait), 32'd1);
        tick();
        chk("con_c3_iwait", 32'(iwait), 32'd0);
        chk("con_c3_iload", iload, 32'hA5A5A5A5);
        chk("con_c3_ramaddr", ramaddr, 32'h80);
`endif
        tick();
        quiet();
        tick();

        // RAM error then retry
        dREN = 1'b1; daddr = 32'h44; ramstate = ERROR;
        tick();
        chk("err_c1_ramREN", 32'(ramREN), 32'd1);
        chk("err_c1_dwait", 32'(dwait), 32'd1);
        chk("err_c1_err", 32'(err), 32'd0);
        tick();
        chk("err_c2_err", 32'(err), 32'd1);
        chk("err_c2_ramREN", 32'(ramREN), 32'd0);
        ramstate = ACCESS; ramload = 32'h11223344;
        tick();
        chk("err_c3_dwait", 32'(dwait), 32'd0);
        chk("err_c3_dload", dload, 32'h11223344);
        chk("err_c3_err", 32'(err), 32'd1);
        tick();
        quiet();
        tick();

        // Withdrawal with a pending instruction request
        dREN = 1'b1; daddr = 32'h500; iaddr = 32'h600; ramstate = BUSY;
        tick();
        iREN = 1'b1;
        #1;
        chk("wd_c1_ramREN", 32'(ramREN), 32'd1);
        chk("wd_c1_ramaddr", ramaddr, 32'h500);
        tick();
        dREN = 1'b0;
        #1;
        chk("wd_c2_ramREN", 32'(ramREN), 32'd0);
        chk("wd_c2_dwait", 32'(dwait), 32'd1);
        tick();
        chk("wd_c3_idle", 32'(ramREN), 32'd0);
        tick();
        ramstate = ACCESS; ramload = 32'h0BADF00D;
        #1;
        chk("wd_c4_ramaddr", ramaddr, 32'h600);
        chk("wd_c4_iwait", 32'(iwait), 32'd0);
        chk("wd_c4_dwait", 32'(dwait), 32'd1);
        tick();
        quiet();
        tick();

        // Reset in the middle of a data service
        dREN = 1'b1; daddr = 32'h700; ramstate = BUSY;
        tick();
        chk("rmid_pre_ramREN", 32'(ramREN), 32'd1);
        RST = 1'b1;
        #1;
        chk("rmid_ramREN", 32'(ramREN), 32'd0);
        chk("rmid_ramWEN", 32'(ramWEN), 32'd0);
        chk("rmid_iwait", 32'(iwait), 32'd1);
        chk("rmid_dwait", 32'(dwait), 32'd1);
        chk("rmid_err", 32'(err), 32'd0);
        chk("rmid_ramaddr", ramaddr, 32'd0);
        quiet();
        tick();
        RST = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
